// File: rtl/gfx_mem_pkg.sv
// Shared types and size constants for the graphics memories.
package gfx_mem_pkg;

  typedef enum logic {CLEAR, READY} gfx_ram_state_t;

  // Where a registered read result comes from on the cycle after the request.
  typedef enum logic [1:0] {
    SRC_ZERO,
    SRC_MEM,
    SRC_CONST,
    SRC_BYP
  } gfx_rd_src_t;

  localparam int TILE_BUF_DEPTH = 300;
  localparam int TILE_GFX_DEPTH = 2048;
  localparam int SPR_GFX_DEPTH  = 2048;
  localparam int PALETTE_DEPTH  = 8;
  localparam int OAM_DEPTH      = 256;

  localparam int PALETTE_W = 24;
  localparam int WORD_W    = 32;

endpackage

// File: rtl/gfx_ram_core.sv
// Bare dual-port array: one byte-enabled write port, two registered read
// ports. No reset anywhere so the array maps onto block RAM. Reads return
// the word as it was before a same-edge write.
module gfx_ram_core
  import gfx_mem_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 2048,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic                clk,
  input  logic                w_en,
  input  logic [DATA_W/8-1:0] w_be,
  input  logic [ADDR_W-1:0]   w_addr,
  input  logic [DATA_W-1:0]   w_data,
  input  logic                ra_en,
  input  logic [ADDR_W-1:0]   ra_addr,
  output logic [DATA_W-1:0]   ra_data,
  input  logic                rb_en,
  input  logic [ADDR_W-1:0]   rb_addr,
  output logic [DATA_W-1:0]   rb_data
);

  localparam int BE_W = DATA_W / 8;

  logic [DATA_W-1:0] mem [DEPTH];

  // Byte-lane write; untouched lanes keep their contents.
  always_ff @(posedge clk) begin
    if (w_en) begin
      for (int i = 0; i < BE_W; i++) begin
        if (w_be[i]) mem[w_addr][8*i +: 8] <= w_data[8*i +: 8];
      end
    end
  end

  // Port A registered read.
  always_ff @(posedge clk) begin
    if (ra_en) ra_data <= mem[ra_addr];
  end

  // Port B registered read.
  always_ff @(posedge clk) begin
    if (rb_en) rb_data <= mem[rb_addr];
  end

endmodule

// File: rtl/gfx_ram.sv
// Parametrised byte-enabled dual-port graphics memory. Port A is the host
// read/write port, port B the display read port. A sequential clear engine
// fills the array with CLEAR_VALUE after reset and on clear_req.
module gfx_ram
  import gfx_mem_pkg::*;
#(
  parameter int                DATA_W      = 32,
  parameter int                DEPTH       = 2048,
  parameter int                ADDR_W      = $clog2(DEPTH),
  parameter logic [DATA_W-1:0] CLEAR_VALUE = '0,
  parameter bit                READ_BYPASS = 1'b1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                clear_req,
  output logic                busy,
  input  logic                a_req,
  input  logic                a_we,
  input  logic [DATA_W/8-1:0] a_be,
  input  logic [ADDR_W-1:0]   a_addr,
  input  logic [DATA_W-1:0]   a_wdata,
  output logic                a_ready,
  output logic [DATA_W-1:0]   a_rdata,
  output logic                a_rvalid,
  input  logic                b_re,
  input  logic [ADDR_W-1:0]   b_addr,
  output logic [DATA_W-1:0]   b_rdata,
  output logic                b_rvalid
);

  localparam int BE_W = DATA_W / 8;

  function automatic logic in_range(input logic [ADDR_W-1:0] addr);
    return 32'(addr) < 32'(DEPTH);
  endfunction

  function automatic logic [DATA_W-1:0] merge_bytes(input logic [DATA_W-1:0] old_w,
                                                    input logic [DATA_W-1:0] new_w,
                                                    input logic [BE_W-1:0]   be);
    logic [DATA_W-1:0] m;
    m = old_w;
    for (int i = 0; i < BE_W; i++) begin
      if (be[i]) m[8*i +: 8] = new_w[8*i +: 8];
    end
    return m;
  endfunction

  gfx_ram_state_t    state, state_nxt;
  logic [ADDR_W-1:0] clr_cnt, clr_cnt_nxt;

  logic              a_acc_p0, a_inr_p0, a_wr_p0, a_rd_p0;
  logic              b_inr_p0, coll_p0;
  gfx_rd_src_t       a_src_p0, b_src_p0;

  logic              w_en;
  logic [BE_W-1:0]   w_be;
  logic [ADDR_W-1:0] w_addr;
  logic [DATA_W-1:0] w_data;
  logic [DATA_W-1:0] core_ra, core_rb;

  logic              a_vld_p1, b_vld_p1;
  gfx_rd_src_t       a_src_p1, b_src_p1;
  logic [DATA_W-1:0] byp_data_p1;
  logic [BE_W-1:0]   byp_be_p1;

  // ---- p0: request decode and clear-engine / port-A write arbitration ----
  assign busy     = (state == CLEAR);
  assign a_ready  = (state == READY);
  assign a_acc_p0 = a_req && a_ready;
  assign a_inr_p0 = in_range(a_addr);
  assign b_inr_p0 = in_range(b_addr);
  assign a_wr_p0  = a_acc_p0 && a_we && a_inr_p0;
  assign a_rd_p0  = a_acc_p0 && !a_we;
  assign coll_p0  = a_wr_p0 && b_re && (a_addr == b_addr);
  assign a_src_p0 = a_inr_p0 ? SRC_MEM : SRC_ZERO;

  assign w_en   = busy || a_wr_p0;
  assign w_be   = busy ? '1 : a_be;
  assign w_addr = busy ? clr_cnt : a_addr;
  assign w_data = busy ? CLEAR_VALUE : a_wdata;

  // Port-B source: out-of-range gives zero, a running clear shows blank, a
  // same-address write is forwarded when bypass is enabled.
  always_comb begin
    b_src_p0 = SRC_MEM;
    if (!b_inr_p0)                    b_src_p0 = SRC_ZERO;
    else if (busy)                    b_src_p0 = SRC_CONST;
    else if (READ_BYPASS && coll_p0)  b_src_p0 = SRC_BYP;
  end

  // Next-state and clear-counter logic; the last clear write hands over to READY.
  always_comb begin
    state_nxt   = state;
    clr_cnt_nxt = clr_cnt;
    unique case (state)
      CLEAR: begin
        if (clr_cnt == ADDR_W'(DEPTH - 1)) begin
          state_nxt   = READY;
          clr_cnt_nxt = '0;
        end else begin
          clr_cnt_nxt = clr_cnt + 1'b1;
        end
      end
      READY: begin
        if (clear_req) begin
          state_nxt   = CLEAR;
          clr_cnt_nxt = '0;
        end
      end
      default: begin
        state_nxt   = CLEAR;
        clr_cnt_nxt = '0;
      end
    endcase
  end

  gfx_ram_core #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_core (
    .clk     (clk),
    .w_en    (w_en),
    .w_be    (w_be),
    .w_addr  (w_addr),
    .w_data  (w_data),
    .ra_en   (a_rd_p0 && a_inr_p0),
    .ra_addr (a_addr),
    .ra_data (core_ra),
    .rb_en   (b_re && b_inr_p0 && !busy),
    .rb_addr (b_addr),
    .rb_data (core_rb)
  );

  // ---- p1: registered control, valids and read-source selects ----
  // Sources only change on a new read so rdata holds between reads.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= CLEAR;
      clr_cnt  <= '0;
      a_vld_p1 <= 1'b0;
      b_vld_p1 <= 1'b0;
      a_src_p1 <= SRC_ZERO;
      b_src_p1 <= SRC_ZERO;
    end else begin
      state    <= state_nxt;
      clr_cnt  <= clr_cnt_nxt;
      a_vld_p1 <= a_rd_p0;
      b_vld_p1 <= b_re;
      if (a_rd_p0) a_src_p1 <= a_src_p0;
      if (b_re)    b_src_p1 <= b_src_p0;
    end
  end

  // Capture the colliding write so port B can merge it over the old word.
  always_ff @(posedge clk) begin
    if (b_re && coll_p0) begin
      byp_data_p1 <= a_wdata;
      byp_be_p1   <= a_be;
    end
  end

  // Read data steering for both ports.
  always_comb begin
    a_rdata = '0;
    if (a_src_p1 == SRC_MEM) a_rdata = core_ra;
    b_rdata = '0;
    unique case (b_src_p1)
      SRC_MEM:   b_rdata = core_rb;
      SRC_CONST: b_rdata = CLEAR_VALUE;
      SRC_BYP:   b_rdata = merge_bytes(core_rb, byp_data_p1, byp_be_p1);
      default:   b_rdata = '0;
    endcase
  end

  assign a_rvalid = a_vld_p1;
  assign b_rvalid = b_vld_p1;

endmodule

// File: tb/tb_gfx_ram.sv
// Self-checking bench for gfx_ram (DEPTH=300). Two instances share stimulus:
// dut forwards same-address writes to port B, dut0 returns the old word.
module tb_gfx_ram;

  localparam int          DW    = 32;
  localparam int          DEPTH = 300;
  localparam int          AW    = $clog2(DEPTH);
  localparam logic [31:0] CV    = 32'h0;

  logic          clk = 1'b0, reset = 1'b1, clear_req = 1'b0;
  logic          a_req = 1'b0, a_we = 1'b0, b_re = 1'b0;
  logic [3:0]    a_be = '0;
  logic [AW-1:0] a_addr = '0, b_addr = '0;
  logic [DW-1:0] a_wdata = '0;

  logic          busy, a_ready, a_rvalid, b_rvalid;
  logic [DW-1:0] a_rdata, b_rdata;
  logic          busy0, a_ready0, a_rvalid0, b_rvalid0;
  logic [DW-1:0] a_rdata0, b_rdata0;

  int passed = 0, total = 0;
  logic [31:0] model [DEPTH];

  always #5 clk = ~clk;

  gfx_ram #(.DATA_W(DW), .DEPTH(DEPTH), .CLEAR_VALUE(CV), .READ_BYPASS(1'b1)) dut (
    .clk(clk), .reset(reset), .clear_req(clear_req), .busy(busy),
    .a_req(a_req), .a_we(a_we), .a_be(a_be), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_ready(a_ready), .a_rdata(a_rdata), .a_rvalid(a_rvalid),
    .b_re(b_re), .b_addr(b_addr), .b_rdata(b_rdata), .b_rvalid(b_rvalid));

  gfx_ram #(.DATA_W(DW), .DEPTH(DEPTH), .CLEAR_VALUE(CV), .READ_BYPASS(1'b0)) dut0 (
    .clk(clk), .reset(reset), .clear_req(clear_req), .busy(busy0),
    .a_req(a_req), .a_we(a_we), .a_be(a_be), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_ready(a_ready0), .a_rdata(a_rdata0), .a_rvalid(a_rvalid0),
    .b_re(b_re), .b_addr(b_addr), .b_rdata(b_rdata0), .b_rvalid(b_rvalid0));

  function automatic bit inr(input logic [AW-1:0] a);
    return int'(a) < DEPTH;
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] n, input logic [3:0] be);
    logic [31:0] m;
    m = o;
    for (int i = 0; i < 4; i++) if (be[i]) m[8*i +: 8] = n[8*i +: 8];
    return m;
  endfunction

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic model_clear();
    for (int i = 0; i < DEPTH; i++) model[i] = CV;
  endtask

  task automatic a_write(input int addr, input logic [31:0] d, input logic [3:0] be);
    a_req = 1'b1; a_we = 1'b1; a_addr = AW'(addr); a_wdata = d; a_be = be;
    if (a_ready === 1'b1 && inr(a_addr)) model[addr] = merge(model[addr], d, be);
    tick();
    a_req = 1'b0; a_we = 1'b0;
  endtask

  task automatic a_read(input int addr, output logic rv, output logic [31:0] rd);
    a_req = 1'b1; a_we = 1'b0; a_addr = AW'(addr);
    tick();
    rv = a_rvalid; rd = a_rdata;
    a_req = 1'b0;
  endtask

  // Count cycles of busy after the current point; bounded.
  task automatic count_busy(output int n);
    n = 0;
    while (busy === 1'b1 && n < 2000) begin tick(); n++; end
  endtask

  task automatic test_reset();
    int n;
    #1 reset = 1'b0;
    #2;
    total++; if (busy !== 1'b1) $display("FAIL reset_busy: got %b want 1", busy); else passed++;
    total++; if (a_ready !== 1'b0) $display("FAIL reset_a_ready: got %b want 0", a_ready); else passed++;
    total++; if (a_rvalid !== 1'b0 || b_rvalid !== 1'b0) $display("FAIL reset_rvalid: got a=%b b=%b want 0", a_rvalid, b_rvalid); else passed++;
    total++; if (a_rdata !== 32'h0 || b_rdata !== 32'h0) $display("FAIL reset_rdata: got a=%h b=%h want 0", a_rdata, b_rdata); else passed++;
    tick(); tick();
    reset = 1'b1;
    count_busy(n);
    total++; if (n != DEPTH) $display("FAIL reset_clear_len: got %0d want %0d", n, DEPTH); else passed++;
    total++; if (a_ready !== 1'b1 || a_ready0 !== 1'b1) $display("FAIL reset_ready_after: got %b/%b want 1", a_ready, a_ready0); else passed++;
    model_clear();
    for (int k = 0; k < 4; k++) begin
      logic rv; logic [31:0] rd; int ad;
      ad = $urandom_range(0, DEPTH - 1);
      a_read(ad, rv, rd);
      total++; if (rv !== 1'b1 || rd !== model[ad]) $display("FAIL reset_read_%0d: got rv=%b %h want 1 %h", ad, rv, rd, model[ad]); else passed++;
    end
  endtask

  task automatic test_byte_enable();
    logic rv; logic [31:0] rd;
    a_write(5, 32'hDEADBEEF, 4'b1111);
    a_write(5, 32'h00001122, 4'b0011);
    a_read(5, rv, rd);
    total++; if (rv !== 1'b1) $display("FAIL be_rvalid: got %b want 1", rv); else passed++;
    total++; if (rd !== model[5]) $display("FAIL be_rdata: got %h want %h", rd, model[5]); else passed++;
    tick();
    total++; if (a_rvalid !== 1'b0) $display("FAIL be_rvalid_pulse: got %b want 0", a_rvalid); else passed++;
    total++; if (a_rdata !== model[5]) $display("FAIL be_rdata_hold: got %h want %h", a_rdata, model[5]); else passed++;
  endtask

  task automatic test_collision();
    logic [31:0] old_w;
    a_write(7, 32'h11111111, 4'b1111);
    old_w = model[7];
    a_req = 1'b1; a_we = 1'b1; a_addr = 7; a_wdata = 32'h22222222; a_be = 4'b1111;
    b_re = 1'b1; b_addr = 7;
    model[7] = merge(model[7], a_wdata, a_be);
    tick();
    a_req = 1'b0; a_we = 1'b0; b_re = 1'b0;
    total++; if (b_rvalid !== 1'b1) $display("FAIL coll_rvalid: got %b want 1", b_rvalid); else passed++;
    total++; if (b_rdata !== model[7]) $display("FAIL coll_bypass: got %h want %h", b_rdata, model[7]); else passed++;
    total++; if (b_rdata0 !== old_w) $display("FAIL coll_no_bypass: got %h want %h", b_rdata0, old_w); else passed++;
  endtask

  task automatic test_out_of_range();
    logic rv; logic [31:0] rd;
    a_write(299, 32'h0BADF00D, 4'b1111);
    a_write(300, 32'h12345678, 4'b1111);
    a_read(300, rv, rd);
    total++; if (rv !== 1'b1 || rd !== 32'h0) $display("FAIL oor_a_read: got rv=%b %h want 1 0", rv, rd); else passed++;
    b_re = 1'b1; b_addr = 300;
    tick();
    b_re = 1'b0;
    total++; if (b_rvalid !== 1'b1 || b_rdata !== 32'h0) $display("FAIL oor_b_read: got rv=%b %h want 1 0", b_rvalid, b_rdata); else passed++;
    a_read(299, rv, rd);
    total++; if (rv !== 1'b1 || rd !== model[299]) $display("FAIL oor_neighbour: got %h want %h", rd, model[299]); else passed++;
  endtask

  task automatic test_back_to_back();
    bit          exp_arv;
    logic [31:0] exp_ard, exp_b1, exp_b0;
    int          bad_a, bad_b;
    bad_a = 0; bad_b = 0;
    for (int c = 0; c < 400; c++) begin
      a_req   = ($urandom_range(0, 3) != 0);
      a_we    = 1'($urandom_range(0, 1));
      a_addr  = AW'($urandom_range(0, DEPTH + 15));
      a_be    = 4'($urandom);
      a_wdata = $urandom;
      b_re    = 1'($urandom_range(0, 1));
      b_addr  = ($urandom_range(0, 2) == 0) ? a_addr : AW'($urandom_range(0, DEPTH + 15));
      exp_arv = a_req && !a_we;
      exp_ard = inr(a_addr) ? model[a_addr] : 32'h0;
      exp_b0  = inr(b_addr) ? model[b_addr] : 32'h0;
      exp_b1  = exp_b0;
      if (a_req && a_we && inr(a_addr)) begin
        if (b_addr == a_addr) exp_b1 = merge(model[a_addr], a_wdata, a_be);
        model[a_addr] = merge(model[a_addr], a_wdata, a_be);
      end
      tick();
      if (a_rvalid !== exp_arv || (exp_arv && a_rdata !== exp_ard)) begin
        if (bad_a == 0) $display("FAIL b2b_port_a cycle %0d: got rv=%b %h want %b %h", c, a_rvalid, a_rdata, exp_arv, exp_ard);
        bad_a++;
      end
      if (b_rvalid !== b_re || b_rvalid0 !== b_re ||
          (b_re && (b_rdata !== exp_b1 || b_rdata0 !== exp_b0))) begin
        if (bad_b == 0) $display("FAIL b2b_port_b cycle %0d: got rv=%b %h/%h want %b %h/%h", c, b_rvalid, b_rdata, b_rdata0, b_re, exp_b1, exp_b0);
        bad_b++;
      end
    end
    a_req = 1'b0; a_we = 1'b0; b_re = 1'b0;
    total++; if (bad_a != 0) $display("FAIL b2b_a_summary: got %0d bad cycles want 0", bad_a); else passed++;
    total++; if (bad_b != 0) $display("FAIL b2b_b_summary: got %0d bad cycles want 0", bad_b); else passed++;
  endtask

  task automatic test_clear();
    int n, bad_stall, bad_b, bad_sweep;
    for (int i = 0; i < DEPTH; i++) a_write(i, 32'hA5A5A5A5, 4'b1111);
    clear_req = 1'b1;
    tick();
    clear_req = 1'b0;
    model_clear();
    total++; if (busy !== 1'b1) $display("FAIL clear_start_busy: got %b want 1", busy); else passed++;
    n = 0; bad_stall = 0; bad_b = 0;
    a_req = 1'b1; a_we = 1'b0; a_addr = 3; b_re = 1'b1;
    while (busy === 1'b1 && n < 2000) begin
      if (a_ready !== 1'b0) bad_stall++;
      b_addr = AW'($urandom_range(0, DEPTH - 1));
      tick(); n++;
      if (a_rvalid !== 1'b0) bad_stall++;
      if (b_rvalid !== 1'b1 || b_rdata !== CV) bad_b++;
    end
    a_req = 1'b0; b_re = 1'b0;
    total++; if (n != DEPTH) $display("FAIL clear_len: got %0d want %0d", n, DEPTH); else passed++;
    total++; if (bad_stall != 0) $display("FAIL clear_stall: got %0d bad cycles want 0", bad_stall); else passed++;
    total++; if (bad_b != 0) $display("FAIL clear_b_blank: got %0d bad cycles want 0", bad_b); else passed++;
    bad_sweep = 0;
    for (int i = 0; i < DEPTH; i++) begin
      a_req = 1'b1; a_addr = AW'(i); b_re = 1'b1; b_addr = AW'(DEPTH - 1 - i);
      tick();
      if (a_rvalid !== 1'b1 || a_rdata !== model[i] || b_rdata !== model[DEPTH - 1 - i]) begin
        if (bad_sweep == 0) $display("FAIL clear_sweep addr %0d: got %h/%h want %h", i, a_rdata, b_rdata, model[i]);
        bad_sweep++;
      end
    end
    a_req = 1'b0; b_re = 1'b0;
    total++; if (bad_sweep != 0) $display("FAIL clear_sweep_summary: got %0d bad want 0", bad_sweep); else passed++;
  endtask

  task automatic test_reset_mid_clear();
    logic rv; logic [31:0] rd;
    int n;
    a_write(20, 32'h5A5A5A5A, 4'b1111);
    a_read(20, rv, rd);
    total++; if (rd !== model[20]) $display("FAIL rmc_pre_read: got %h want %h", rd, model[20]); else passed++;
    clear_req = 1'b1;
    tick();
    clear_req = 1'b0;
    b_re = 1'b1; b_addr = 10;
    repeat (100) tick();
    total++; if (b_rvalid !== 1'b1 || busy !== 1'b1) $display("FAIL rmc_mid: got b_rvalid=%b busy=%b want 1 1", b_rvalid, busy); else passed++;
    reset = 1'b0; b_re = 1'b0;
    #1;
    total++; if (busy !== 1'b1 || a_ready !== 1'b0) $display("FAIL rmc_ctrl: got busy=%b ready=%b want 1 0", busy, a_ready); else passed++;
    total++; if (a_rvalid !== 1'b0 || b_rvalid !== 1'b0) $display("FAIL rmc_rvalid: got %b %b want 0 0", a_rvalid, b_rvalid); else passed++;
    total++; if (a_rdata !== 32'h0 || b_rdata !== 32'h0) $display("FAIL rmc_rdata: got %h %h want 0 0", a_rdata, b_rdata); else passed++;
    @(posedge clk); #1;
    reset = 1'b1;
    model_clear();
    count_busy(n);
    total++; if (n != DEPTH) $display("FAIL rmc_clear_len: got %0d want %0d", n, DEPTH); else passed++;
    a_read(20, rv, rd);
    total++; if (rv !== 1'b1 || rd !== model[20]) $display("FAIL rmc_post_read: got %b %h want 1 %h", rv, rd, model[20]); else passed++;
  endtask

  initial begin
    test_reset();
    test_byte_enable();
    test_collision();
    test_out_of_range();
    test_back_to_back();
    test_clear();
    test_reset_mid_clear();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/gfx_ram.md
# gfx_ram

Parametrised, byte-enabled, dual-port graphics memory. It replaces the fixed-size tile buffer, tile graphics, sprite graphics, palette and OAM stores with one block. Port A is the host (Avalon-facing) read/write port; port B is the read-only port used by the display pipeline. Memory contents are cleared by a sequential clear engine after reset and on request, not by a parallel reset of the array, so the array maps onto block RAM.

## Interface
Parameters:
- DATA_W, 32, word width in bits; must be a multiple of 8 (24 for palettes).
- DEPTH, 2048, number of words; need not be a power of two (300 for the tile buffer).
- ADDR_W, $clog2(DEPTH), address width.
- CLEAR_VALUE, '0, word written by the clear engine.
- READ_BYPASS, 1, port-B read-during-write to the same address: 1 returns new data, 0 returns old data.

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- clear_req  in  1  one-cycle pulse; starts a full clear.
- busy  out  1  high while the clear engine runs.
- a_req  in  1  port-A request.
- a_we  in  1  port-A write (1) or read (0).
- a_be  in  DATA_W/8  port-A byte enables; writes only.
- a_addr  in  ADDR_W  port-A address.
- a_wdata  in  DATA_W  port-A write data.
- a_ready  out  1  port-A accept; a request is taken when a_req && a_ready.
- a_rdata  out  DATA_W  port-A read data.
- a_rvalid  out  1  one-cycle read-data strobe.
- b_re  in  1  port-B read enable.
- b_addr  in  ADDR_W  port-B address.
- b_rdata  out  DATA_W  port-B read data.
- b_rvalid  out  1  one-cycle read-data strobe.

## Operation
- FSM states: CLEAR and READY.
  - reset low: state=CLEAR, clear counter=0.
  - CLEAR: one word per cycle is written with CLEAR_VALUE at the counter address, and the counter increments. Once address DEPTH-1 has been written, the next state is READY.
  - READY: clear_req moves the FSM to CLEAR with the counter at 0. clear_req received during CLEAR is ignored.
- busy = (state==CLEAR).
- a_ready = (state==READY); port A is stalled throughout a clear.
- Port-A write: for each byte i where a_be[i]=1, mem[a_addr][8i+7:8i] <= a_wdata. Bytes with a_be[i]=0 are left unchanged.
- Port-A read: returns mem[a_addr].
- Port B is never stalled.
  - During CLEAR, each b_re returns CLEAR_VALUE with b_rvalid=1, so the display shows blank.
- Out-of-range address (addr >= DEPTH), either port: writes are dropped, reads return '0 with rvalid=1.
- Same-address collision, port-A write and port-B read in the same cycle: port B returns the byte-merged new word if READ_BYPASS=1, otherwise the old word.
- Reset mid-clear, or mid-transaction: the clear restarts from address 0. Pending rvalids are dropped.

## Timing
- Reset values: busy=1, a_ready=0, a_rvalid=0, b_rvalid=0, a_rdata='0, b_rdata='0.
- Read latency is 1 cycle on both ports:
  - A request accepted at edge N gives rdata/rvalid valid after edge N.
  - rvalid is high for one cycle only. rdata holds its value until the next read.
- Write latency: a write accepted at edge N is visible to a port-A read issued at edge N+1.
- Clear duration:
  - After reset deassertion: exactly DEPTH cycles of busy=1, with a_ready rising on cycle DEPTH.
  - clear_req accepted at edge N: busy=1 from after edge N for DEPTH cycles.
- Back-to-back requests are allowed every cycle on both ports.

## Structure
- Package gfx_mem_pkg holds:
  - typedef enum {CLEAR, READY} gfx_ram_state_t;
  - depth constants TILE_BUF_DEPTH=300, TILE_GFX_DEPTH=2048, SPR_GFX_DEPTH=2048, PALETTE_DEPTH=8, OAM_DEPTH=256;
  - width constants PALETTE_W=24, WORD_W=32.
- Sub-module gfx_ram_core: bare dual-port array with a byte-enabled write on one port and registered reads on both. It has no reset, so the array is inferred as block RAM.
- gfx_ram contains the FSM, the clear counter, the port muxing (clear engine vs port A), range checks, bypass logic and the valid registers.

## Test plan
- Reset release, DEPTH=300: busy=1 for exactly 300 cycles, then a_ready=1. A read of any address returns 0.
- Byte-enable write:
  - Write 0xDEADBEEF to addr 5 with be=4'b1111.
  - Then write 0x00001122 with be=4'b0011.
  - Read addr 5 -> 0xDEAD1122, with a_rvalid one cycle after acceptance.
- Collision: mem[7]=0x11111111, then a port-A write of 0x22222222 to addr 7 in the same cycle as a b_re of addr 7.
  - READY_BYPASS=1: b_rdata=0x22222222.
  - READ_BYPASS=0: b_rdata=0x11111111.
- Out of range, DEPTH=300:
  - A write to addr 300 is dropped.
  - A read of addr 300 returns 0 with rvalid=1.
  - addr 299 is unchanged.
- clear_req after filling memory with 0xA5A5A5A5:
  - busy for DEPTH cycles, and a_req is stalled with a_ready=0.
  - b_re during the clear returns CLEAR_VALUE.
  - After the clear, every address reads CLEAR_VALUE.
- reset asserted at clear cycle 100: all outputs are at their reset values immediately. After release, busy lasts a full DEPTH cycles.
